// File: rtl/stack.sv
// LIFO stack with indexed peek/poke, one command per cycle (push > pop > poke > peek).
// data_out shows the selected item in the command cycle and holds it afterwards.
module stack #(
  parameter int unsigned WIDTH = 56,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_en,
  input  logic                   pop_en,
  input  logic                   peek_en,
  input  logic                   poke_en,
  input  logic [$clog2(DEPTH):0] index,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] depth
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_PUSH,
    CMD_POP,
    CMD_POKE,
    CMD_PEEK
  } cmd_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  cmd_e             cmd;
  logic             idx_ok;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    idx_addr;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;

  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == DW'(0));
  assign depth    = depth_q;

  assign idx_ok   = (index < depth_q);
  assign top_addr = AW'(depth_q - DW'(1));
  assign idx_addr = AW'(depth_q - DW'(1) - index);

  // The highest-priority asserted enable owns the cycle, even if it turns out invalid.
  always_comb begin
    cmd = CMD_NONE;
    if (push_en) begin
      if (!full) cmd = CMD_PUSH;
    end else if (pop_en) begin
      if (!empty) cmd = CMD_POP;
    end else if (poke_en) begin
      if (idx_ok) cmd = CMD_POKE;
    end else if (peek_en) begin
      if (idx_ok) cmd = CMD_PEEK;
    end
  end

  assign rd_valid = (cmd == CMD_POP) || (cmd == CMD_PEEK);
  assign rd_addr  = (cmd == CMD_POP) ? top_addr : idx_addr;
  assign rd_data  = mem_q[rd_addr];
  assign data_out = rd_valid ? rd_data : dout_q;

  // Next-state for depth, held output and array write port.
  always_comb begin
    depth_d = depth_q;
    dout_d  = dout_q;
    wr_en   = 1'b0;
    wr_addr = AW'(depth_q);
    unique case (cmd)
      CMD_PUSH: begin
        depth_d = depth_q + DW'(1);
        wr_en   = 1'b1;
        wr_addr = AW'(depth_q);
      end
      CMD_POP: begin
        depth_d = depth_q - DW'(1);
        dout_d  = rd_data;
      end
      CMD_POKE: begin
        wr_en   = 1'b1;
        wr_addr = idx_addr;
      end
      CMD_PEEK: begin
        dout_d  = rd_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      dout_q  <= '0;
    end else begin
      depth_q <= depth_d;
      dout_q  <= dout_d;
    end
  end

  // Storage is deliberately left out of reset; depth alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= data_in;
  end

endmodule

// File: tb/tb_stack.sv
// Directed table-driven bench for the stack, plus hand sequences for fill/drain,
// poke/peek bounds and asynchronous mid-stream reset.
module tb_stack;

  localparam int unsigned WIDTH = 56;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_en, pop_en, peek_en, poke_en;
  logic [DW-1:0]    index;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full, empty;
  logic [DW-1:0]    depth;

  int checks   = 0;
  int failures = 0;

  stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .push_en (push_en),
    .pop_en  (pop_en),
    .peek_en (peek_en),
    .poke_en (poke_en),
    .index   (index),
    .data_in (data_in),
    .data_out(data_out),
    .full    (full),
    .empty   (empty),
    .depth   (depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          push, pop, peek, poke;
    int            idx;
    logic [55:0]   din;
    logic [55:0]   exp_dout;   // data_out during the command cycle
    int            exp_depth;  // depth after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pu, input logic po, input logic pk, input logic pz,
                              input int idx, input logic [55:0] din,
                              input logic [55:0] ed, input int edep);
    vec_t v;
    v.push = pu; v.pop = po; v.peek = pk; v.poke = pz;
    v.idx = idx; v.din = din; v.exp_dout = ed; v.exp_depth = edep;
    return v;
  endfunction

  // Drive one command, check data_out inside the cycle, then depth/flags after the edge.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    push_en = v.push; pop_en = v.pop; peek_en = v.peek; poke_en = v.poke;
    index   = DW'(v.idx);
    data_in = v.din;
    #1;
    chk({name, " data_out"}, 64'(data_out), 64'(v.exp_dout));
    @(posedge clk);
    #1;
    chk({name, " depth"}, 64'(depth), 64'(v.exp_depth));
    chk({name, " full"},  64'(full),  64'(v.exp_depth == DEPTH));
    chk({name, " empty"}, 64'(empty), 64'(v.exp_depth == 0));
  endtask

  task automatic idle();
    @(negedge clk);
    push_en = 0; pop_en = 0; peek_en = 0; poke_en = 0;
  endtask

  initial begin
    rst = 1'b1;
    push_en = 0; pop_en = 0; peek_en = 0; poke_en = 0;
    index = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset depth", 64'(depth), 64'd0);
    chk("reset empty", 64'(empty), 64'd1);
    chk("reset full",  64'(full),  64'd0);
    chk("reset data_out", 64'(data_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    //          push pop peek poke idx din     exp_dout exp_depth
    vecs.push_back(mk(1, 0, 0, 0, 0, 56'h11, 56'h00, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 56'h22, 56'h00, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 56'h33, 56'h00, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 56'h00, 56'h33, 3));
    vecs.push_back(mk(0, 0, 1, 0, 1, 56'h00, 56'h22, 3));
    vecs.push_back(mk(0, 0, 1, 0, 2, 56'h00, 56'h11, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 56'h00, 56'h11, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 56'h00, 56'h33, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 56'h00, 56'h33, 2));
    vecs.push_back(mk(0, 0, 1, 0, 2, 56'h00, 56'h33, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 56'hAB, 56'h33, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 56'h00, 56'hAB, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 56'h44, 56'hAB, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 56'h00, 56'h44, 2));
    vecs.push_back(mk(0, 1, 0, 0, 0, 56'h00, 56'hAB, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 56'h55, 56'hAB, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 56'h00, 56'h55, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 56'h66, 56'h55, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 56'h00, 56'h66, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 56'h00, 56'h66, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 56'h00, 56'h66, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 56'h00, 56'h66, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 56'h77, 56'h66, 0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Fill to full, overflow push ignored, drain, underflow pop ignored.
    for (int i = 1; i <= 8; i++)
      apply(mk(1, 0, 0, 0, 0, 56'(i), 56'h66, i), $sformatf("fill%0d", i));
    apply(mk(1, 0, 0, 0, 0, 56'h99, 56'h66, 8), "push_full");
    apply(mk(0, 0, 1, 0, 0, 56'h00, 56'h08, 8), "top_after_full");
    for (int i = 8; i >= 1; i--)
      apply(mk(0, 1, 0, 0, 0, 56'h00, 56'(i), i - 1), $sformatf("drain%0d", i));
    apply(mk(0, 1, 0, 0, 0, 56'h00, 56'h01, 0), "pop_empty");

    // Stack [top 5, 7, 9]: poke index 2, then out-of-range poke/peek at index 3.
    apply(mk(1, 0, 0, 0, 0, 56'h09, 56'h01, 1), "p9");
    apply(mk(1, 0, 0, 0, 0, 56'h07, 56'h01, 2), "p7");
    apply(mk(1, 0, 0, 0, 0, 56'h05, 56'h01, 3), "p5");
    apply(mk(0, 0, 0, 1, 2, 56'hAA, 56'h01, 3), "poke2");
    apply(mk(0, 0, 1, 0, 2, 56'h00, 56'hAA, 3), "peek2");
    apply(mk(0, 0, 0, 1, 3, 56'hBB, 56'hAA, 3), "poke3");
    apply(mk(0, 0, 1, 0, 3, 56'h00, 56'hAA, 3), "peek3");
    apply(mk(0, 0, 1, 0, 0, 56'h00, 56'h05, 3), "peek0");
    apply(mk(0, 0, 1, 0, 1, 56'h00, 56'h07, 3), "peek1");
    apply(mk(0, 0, 1, 0, 2, 56'h00, 56'hAA, 3), "peek2b");
    apply(mk(1, 0, 0, 0, 0, 56'hCC, 56'h00AA, 4), "pCC");

    // Asynchronous reset mid-cycle with a pop pending.
    @(negedge clk);
    push_en = 0; pop_en = 1; peek_en = 0; poke_en = 0;
    #1;
    chk("pre_rst data_out", 64'(data_out), 64'hCC);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst depth", 64'(depth), 64'd0);
    chk("async_rst empty", 64'(empty), 64'd1);
    chk("async_rst full",  64'(full),  64'd0);
    chk("async_rst data_out", 64'(data_out), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold depth", 64'(depth), 64'd0);
    idle();
    rst = 1'b0;
    apply(mk(1, 0, 0, 0, 0, 56'h77, 56'h00, 1), "post_rst_push");
    apply(mk(0, 0, 1, 0, 0, 56'h00, 56'h77, 1), "post_rst_peek");
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
